// File: rtl/prog_loader.sv
// UART boot loader: receives a framed, checksummed program image and writes it word by word
// into program memory, holding the core in reset until a complete image has been verified.
module prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx,
  output logic        o_pm_we,
  output logic [31:0] o_pm_addr,
  output logic [31:0] o_pm_wdata,
  output logic        o_cpu_reset,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned MaxWords = 1 << ADDR_W;
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitM1  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [7:0] SyncByte = 8'hA5;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {FrIdle, FrLen0, FrLen1, FrData, FrCsum} fr_state_e;

  // ---------------- RX front end ----------------
  logic            r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_e       r_rx_state, w_rx_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_byte_valid, w_byte_valid_nxt;
  logic            r_frame_err, w_frame_err_nxt;
  logic            w_fall;

  assign w_fall = r_rx_prev & ~r_rx_sync;

  // Synchroniser resets low so a line held low across reset never looks like a start edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_meta    <= 1'b0;
      r_rx_sync    <= 1'b0;
      r_rx_prev    <= 1'b0;
      r_rx_state   <= RxIdle;
      r_cnt        <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_meta    <= i_rx;
      r_rx_sync    <= r_rx_meta;
      r_rx_prev    <= r_rx_sync;
      r_rx_state   <= w_rx_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt   = r_rx_state;
    w_cnt_nxt        = r_cnt + 1'b1;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_byte_valid_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;
    unique case (r_rx_state)
      RxIdle: begin
        w_cnt_nxt = '0;
        if (w_fall) w_rx_state_nxt = RxStart;
      end
      RxStart: begin
        if (r_cnt == HalfM1) begin
          w_cnt_nxt      = '0;
          w_bit_cnt_nxt  = '0;
          w_rx_state_nxt = r_rx_sync ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (r_cnt == BitM1) begin
          w_cnt_nxt     = '0;
          w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) w_rx_state_nxt = RxStop;
        end
      end
      RxStop: begin
        if (r_cnt == BitM1) begin
          w_cnt_nxt        = '0;
          w_byte_valid_nxt = r_rx_sync;
          w_frame_err_nxt  = ~r_rx_sync;
          w_rx_state_nxt   = RxIdle;
        end
      end
      default: w_rx_state_nxt = RxIdle;
    endcase
  end

  // ---------------- Frame FSM ----------------
  fr_state_e       r_state, w_state_nxt;
  logic [15:0]     r_len, w_len_nxt;
  logic [ADDR_W:0] r_widx, w_widx_nxt;
  logic [1:0]      r_lane, w_lane_nxt;
  logic [7:0]      r_csum, w_csum_nxt;
  logic [31:0]     r_word, w_word_nxt;
  logic            r_pm_we, w_pm_we_nxt;
  logic [31:0]     r_pm_addr, w_pm_addr_nxt;
  logic [31:0]     r_pm_wdata, w_pm_wdata_nxt;
  logic            r_cpu_reset, w_cpu_reset_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;
  logic [15:0]     w_len_full;
  logic [ADDR_W:0] w_widx_inc;
  logic [31:0]     w_word_full;

  assign w_len_full  = {r_shift, r_len[7:0]};
  assign w_widx_inc  = r_widx + 1'b1;
  assign w_word_full = {r_shift, r_word[31:8]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= FrIdle;
      r_len       <= '0;
      r_widx      <= '0;
      r_lane      <= '0;
      r_csum      <= '0;
      r_word      <= '0;
      r_pm_we     <= 1'b0;
      r_pm_addr   <= '0;
      r_pm_wdata  <= '0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_widx      <= w_widx_nxt;
      r_lane      <= w_lane_nxt;
      r_csum      <= w_csum_nxt;
      r_word      <= w_word_nxt;
      r_pm_we     <= w_pm_we_nxt;
      r_pm_addr   <= w_pm_addr_nxt;
      r_pm_wdata  <= w_pm_wdata_nxt;
      r_cpu_reset <= w_cpu_reset_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_widx_nxt      = r_widx;
    w_lane_nxt      = r_lane;
    w_csum_nxt      = r_csum;
    w_word_nxt      = r_word;
    w_pm_we_nxt     = 1'b0;
    w_pm_addr_nxt   = r_pm_addr;
    w_pm_wdata_nxt  = r_pm_wdata;
    w_cpu_reset_nxt = r_cpu_reset;
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;
    w_err_nxt       = r_err;
    if (r_frame_err) begin
      // Abort the load; words already written stay in memory.
      w_err_nxt       = 1'b1;
      w_busy_nxt      = 1'b0;
      w_cpu_reset_nxt = 1'b1;
      w_done_nxt      = 1'b0;
      w_state_nxt     = FrIdle;
    end else if (r_byte_valid) begin
      unique case (r_state)
        FrIdle: begin
          if (r_shift == SyncByte) begin
            w_busy_nxt      = 1'b1;
            w_cpu_reset_nxt = 1'b1;
            w_done_nxt      = 1'b0;
            w_err_nxt       = 1'b0;
            w_widx_nxt      = '0;
            w_lane_nxt      = '0;
            w_csum_nxt      = '0;
            w_state_nxt     = FrLen0;
          end
        end
        FrLen0: begin
          w_len_nxt   = {8'h00, r_shift};
          w_state_nxt = FrLen1;
        end
        FrLen1: begin
          w_len_nxt = w_len_full;
          if (32'(w_len_full) > MaxWords) begin
            w_err_nxt       = 1'b1;
            w_busy_nxt      = 1'b0;
            w_cpu_reset_nxt = 1'b1;
            w_state_nxt     = FrIdle;
          end else if (w_len_full == 16'd0) begin
            w_state_nxt = FrCsum;
          end else begin
            w_state_nxt = FrData;
          end
        end
        FrData: begin
          w_word_nxt = w_word_full;
          w_csum_nxt = r_csum + r_shift;
          w_lane_nxt = r_lane + 1'b1;
          if (r_lane == 2'd3) begin
            w_pm_we_nxt    = 1'b1;
            w_pm_addr_nxt  = {{(30 - ADDR_W){1'b0}}, r_widx[ADDR_W-1:0], 2'b00};
            w_pm_wdata_nxt = w_word_full;
            w_widx_nxt     = w_widx_inc;
            if (32'(w_widx_inc) == 32'(r_len)) w_state_nxt = FrCsum;
          end
        end
        FrCsum: begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = FrIdle;
          if (r_shift == r_csum) begin
            w_done_nxt      = 1'b1;
            w_cpu_reset_nxt = 1'b0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        default: w_state_nxt = FrIdle;
      endcase
    end
  end

  assign o_pm_we     = r_pm_we;
  assign o_pm_addr   = r_pm_addr;
  assign o_pm_wdata  = r_pm_wdata;
  assign o_cpu_reset = r_cpu_reset;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of framed byte streams with expected writes and
// flags, plus hand sequences for reset mid-frame and a short rx glitch.
module tb_prog_loader;

  localparam int unsigned CPB    = 8;
  localparam int unsigned ADDR_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        pm_we;
  logic [31:0] pm_addr;
  logic [31:0] pm_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_rx       (rx),
    .o_pm_we    (pm_we),
    .o_pm_addr  (pm_addr),
    .o_pm_wdata (pm_wdata),
    .o_cpu_reset(cpu_reset),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  typedef struct packed {
    logic [127:0] stream;   // first byte in the top bits
    logic [4:0]   nbytes;
    logic [4:0]   bad_idx;  // byte sent with stop bit low; 31 = none
    logic [1:0]   nwr;
    logic [31:0]  a0, d0, a1, d1;
    logic         exp_done, exp_err, exp_cpu_reset, exp_busy;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic        prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Capture every write strobe; a strobe wider than one cycle is an error.
  always @(negedge clk) begin
    if (pm_we) begin
      wr_addr.push_back(pm_addr);
      wr_data.push_back(pm_wdata);
      n_checks++;
      if (prev_we) begin
        n_errors++;
        $display("FAIL pm_we_width: got 2+ cycles, expected 1");
      end
    end
    prev_we = pm_we;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_stream(input logic [127:0] s, input int n, input int bad);
    logic [127:0] t;
    t = s;
    for (int i = 0; i < n; i++) send_byte(t[127-8*i -: 8], (i == bad) ? 1'b0 : 1'b1);
  endtask

  function automatic vec_t mk(input logic [127:0] s, input int n, input int bad, input int nwr,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic dn, input logic er, input logic cr, input logic bs);
    vec_t v;
    v.stream = s;  v.nbytes = 5'(n);  v.bad_idx = 5'(bad);  v.nwr = 2'(nwr);
    v.a0 = a0;  v.d0 = d0;  v.a1 = a1;  v.d1 = d1;
    v.exp_done = dn;  v.exp_err = er;  v.exp_cpu_reset = cr;  v.exp_busy = bs;
    return v;
  endfunction

  task automatic check_outputs_reset(input string tag);
    check({tag, " pm_we"}, 32'(pm_we), 32'd0);
    check({tag, " pm_addr"}, pm_addr, 32'd0);
    check({tag, " pm_wdata"}, pm_wdata, 32'd0);
    check({tag, " cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
  endtask

  localparam logic [127:0] Good = 128'hA5020013_005000B3_00500066_00000000;

  vec_t vecs[8];

  initial begin
    vecs[0] = mk(Good, 12, 31, 2, 32'h0, 32'h00500013, 32'h4, 32'h005000B3, 1, 0, 0, 0);
    vecs[1] = mk(128'hA5020013_005000B3_00500067_00000000, 12, 31, 2,
                 32'h0, 32'h00500013, 32'h4, 32'h005000B3, 0, 1, 1, 0);
    vecs[2] = mk(128'hA5000000_00000000_00000000_00000000, 4, 31, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[3] = mk(128'hA5020013_00500000_00000000_00000000, 6, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    vecs[4] = vecs[0];
    vecs[5] = mk(128'h00FF5A00_00000000_00000000_00000000, 3, 31, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // 17 words exceeds the 16-word image limit for ADDR_W=4.
    vecs[6] = mk(128'hA5110000_00000000_00000000_00000000, 3, 31, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    vecs[7] = mk(128'hA50100A5_010203AB_00000000_00000000, 8, 31, 1,
                 32'h0, 32'h030201A5, 0, 0, 1, 0, 0, 0);

    rx    = 1'b1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_outputs_reset("por");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      wr_addr.delete();
      wr_data.delete();
      send_stream(vecs[v].stream, int'(vecs[v].nbytes), int'(vecs[v].bad_idx));
      repeat (CPB) @(negedge clk);
      check($sformatf("v%0d nwr", v), 32'(wr_addr.size()), 32'(vecs[v].nwr));
      if (vecs[v].nwr >= 1 && wr_addr.size() >= 1) begin
        check($sformatf("v%0d addr0", v), wr_addr[0], vecs[v].a0);
        check($sformatf("v%0d data0", v), wr_data[0], vecs[v].d0);
      end
      if (vecs[v].nwr >= 2 && wr_addr.size() >= 2) begin
        check($sformatf("v%0d addr1", v), wr_addr[1], vecs[v].a1);
        check($sformatf("v%0d data1", v), wr_data[1], vecs[v].d1);
      end
      check($sformatf("v%0d done", v), 32'(done), 32'(vecs[v].exp_done));
      check($sformatf("v%0d err", v), 32'(err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d cpu_reset", v), 32'(cpu_reset), 32'(vecs[v].exp_cpu_reset));
      check($sformatf("v%0d busy", v), 32'(busy), 32'(vecs[v].exp_busy));
    end

    // Short low glitch on rx: rejected at the start-bit re-check.
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch err", 32'(err), 32'd0);
    check("glitch busy", 32'(busy), 32'd0);
    check("glitch done", 32'(done), 32'd1);

    // Reset in the middle of the second word, with rx held low across deassertion.
    wr_addr.delete();
    wr_data.delete();
    send_stream(Good, 8, 31);
    repeat (2) @(negedge clk);
    check("mid busy", 32'(busy), 32'd1);
    check("mid cpu_reset", 32'(cpu_reset), 32'd1);
    check("mid nwr", 32'(wr_addr.size()), 32'd1);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_reset("midrst");
    reset = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("postrst err", 32'(err), 32'd0);
    check("postrst busy", 32'(busy), 32'd0);

    wr_addr.delete();
    wr_data.delete();
    send_stream(Good, 12, 31);
    repeat (CPB) @(negedge clk);
    check("reload nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() >= 2) begin
      check("reload addr0", wr_addr[0], 32'h0);
      check("reload data0", wr_data[0], 32'h00500013);
      check("reload addr1", wr_addr[1], 32'h4);
      check("reload data1", wr_data[1], 32'h005000B3);
    end
    check("reload done", 32'(done), 32'd1);
    check("reload cpu_reset", 32'(cpu_reset), 32'd0);
    check("reload err", 32'(err), 32'd0);
    check("hold wdata", pm_wdata, 32'h005000B3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

UART boot loader that writes a program image into program memory, the writer on the program-memory port that the core's fetch stage reads. It deserialises a framed byte stream on `rx`, assembles little-endian 32-bit words and issues single-cycle word writes at word-aligned byte addresses matching the core's PC, starting at 0. It holds the core in reset until a complete frame with a valid checksum has been written.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4
- ADDR_W, 8, word-address width; the image is at most 2^ADDR_W words
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous, active-high reset
- rx  in  1  UART serial input, idle high, 8N1, LSB first; asynchronous to clk
- pm_we  out  1  program-memory write strobe, one-cycle pulse per word
- pm_addr  out  32  byte address of the write = 4 × word index; bits [1:0] always 0
- pm_wdata  out  32  write data; valid while pm_we=1
- cpu_reset  out  1  core reset request; high while not loaded
- busy  out  1  high from sync-byte acceptance until DONE or error
- done  out  1  high after a successful load, until the next sync byte
- err  out  1  sticky error flag; cleared by reset or by the next sync byte

## Operation
- Reset values: pm_we=0, pm_addr=0, pm_wdata=0, cpu_reset=1, busy=0, done=0, err=0. The RX FSM and the frame FSM both go to idle.
- RX front end:
  - 2-flop synchroniser on rx.
  - A high-to-low transition of the synchronised rx starts a frame.
  - The start bit is re-checked at CLKS_PER_BIT/2. If rx is high there, it is a glitch: return to idle with no error.
  - 8 data bits are sampled at mid-bit, LSB first. The stop bit is sampled at mid-bit.
  - Stop=1 gives a one-cycle `byte_valid`. Stop=0 is a framing error.
- Frame format: sync 0xA5, count N as 16 bits little-endian, N×4 data bytes (each word little-endian), then checksum = sum of all data bytes mod 256.
- Frame FSM states:
  - IDLE: non-0xA5 bytes are ignored. On 0xA5: busy=1, cpu_reset=1, done=0, err=0, word index=0, checksum accumulator=0. Go to LEN0.
  - LEN0 → LEN1 (count low byte, then high byte).
  - After LEN1: if N > 2^ADDR_W, set err and go to IDLE. If N=0, go to CSUM. Otherwise go to DATA.
  - DATA: each byte shifts into byte lane (byte count mod 4) and adds to the checksum. On the 4th byte, pulse pm_we with pm_addr=4×index, then increment the index. After word N, go to CSUM.
  - CSUM: a match goes to DONE (done=1, busy=0, cpu_reset=0). A mismatch sets err, busy=0, cpu_reset stays 1, and the FSM returns to IDLE.
  - DONE: behaves as IDLE. A 0xA5 starts a new load and reasserts cpu_reset.
- Framing error in any state: err=1, busy=0, cpu_reset=1, frame FSM to IDLE. Words already written are not rolled back.
- pm_addr and pm_wdata hold their last values between strobes.

## Timing
- byte_valid fires the cycle after the stop-bit mid-sample. A full byte takes about 9.5 bit-times from the start edge, plus 2 cycles of synchroniser latency.
- pm_we is asserted the cycle after byte_valid of the 4th byte of a word. It lasts exactly 1 cycle.
- done, busy and cpu_reset update the cycle after byte_valid of the checksum byte.
- The RX FSM returns to idle after the stop-bit sample. A new start edge is accepted immediately, so back-to-back bytes with no idle time are supported.
- reset asserted mid-byte or mid-frame: all outputs return to reset values on the next edge and the partial frame is discarded. rx held low through the deassertion of reset does not start a frame until a high-to-low edge is seen.

## Test plan
- CLKS_PER_BIT=8, frame A5 02 00 | 13 00 50 00 | B3 00 50 00 | checksum 0x66 -> pm_we pulses twice: (addr 0x0, 0x00500013) then (addr 0x4, 0x005000B3). Then done=1, cpu_reset=0, err=0.
- Same frame with checksum 0x67 -> both writes occur. Then err=1, done=0, cpu_reset=1.
- Frame A5 00 00 00 (N=0, checksum 0) -> no pm_we, done=1, cpu_reset=0.
- Stop bit forced low during the 3rd data byte -> err=1, busy=0, no further pm_we. A following valid frame clears err and loads.
- Garbage bytes 00 FF 5A before the sync byte -> ignored with no state change. Separately, a 2-cycle low glitch on rx -> no byte_valid and no err.
- reset pulsed during the 2nd word -> all outputs return to reset values. A subsequent full frame loads correctly starting at addr 0.
